// File: rtl/parse_ascii_hex_if.sv
// Byte-in / word-out bus for the ASCII hex line parser.
//   master : drives iCHAR/iCHAR_VALID and observes the parsed results
//   slave  : the parser side, which accepts characters and drives the results
//   iCHAR        8           received ASCII byte
//   iCHAR_VALID  1           iCHAR valid this cycle
//   oDATA        DATA_WIDTH  last successfully parsed word
//   oDATA_VALID  1           one-cycle pulse, oDATA updated
//   oERR         1           one-cycle pulse, current line rejected
//   oBUSY        1           partial line in progress
interface parse_ascii_hex_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [7:0]            iCHAR;
  logic                  iCHAR_VALID;
  logic [DATA_WIDTH-1:0] oDATA;
  logic                  oDATA_VALID;
  logic                  oERR;
  logic                  oBUSY;

  modport master (
    output iCHAR, iCHAR_VALID,
    input  oDATA, oDATA_VALID, oERR, oBUSY
  );

  modport slave (
    input  iCHAR, iCHAR_VALID,
    output oDATA, oDATA_VALID, oERR, oBUSY
  );
endinterface

// File: rtl/parse_ascii_hex.sv
// Assembles lines of exactly DATA_WIDTH/4 ASCII hex digits (MSB first, ended by
// CR or LF) into binary words. Malformed lines raise a one-cycle oERR and are
// discarded up to the next end-of-line.
//   CLK  : single clock
//   RST  : synchronous reset, active-high
//   bus  : parse_ascii_hex_if slave (character input, parsed word/flags output)
module parse_ascii_hex #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                CLK,
  input  logic                RST,
  parse_ascii_hex_if.slave    bus
);

  localparam int unsigned NDIG  = DATA_WIDTH / 4;
  localparam int unsigned CNT_W = (NDIG < 2) ? 1 : $clog2(NDIG + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    WAIT_EOL = 2'd2,
    DISCARD  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  dvalid_q, dvalid_d;
  logic                  err_q, err_d;
  logic                  busy_q;

  logic       is_hex;
  logic       is_eol;
  logic [3:0] nib;
  logic       last_dig;

  // Character classification and nibble decode; letters map to 10..15.
  always_comb begin
    is_hex = 1'b0;
    nib    = 4'd0;
    if (bus.iCHAR >= 8'h30 && bus.iCHAR <= 8'h39) begin
      is_hex = 1'b1;
      nib    = bus.iCHAR[3:0];
    end else if ((bus.iCHAR >= 8'h41 && bus.iCHAR <= 8'h46) ||
                 (bus.iCHAR >= 8'h61 && bus.iCHAR <= 8'h66)) begin
      is_hex = 1'b1;
      nib    = 4'(bus.iCHAR[3:0] + 4'd9);
    end
    is_eol = (bus.iCHAR == 8'h0D) || (bus.iCHAR == 8'h0A);
  end

  // The digit being accepted in COLLECT completes the word.
  assign last_dig = (cnt_q == CNT_W'(NDIG - 1));

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.iCHAR_VALID) begin
      unique case (state_q)
        IDLE: begin
          if (is_hex)       state_d = (NDIG == 1) ? WAIT_EOL : COLLECT;
          else if (!is_eol) state_d = DISCARD;
        end
        COLLECT: begin
          if (is_hex)      state_d = last_dig ? WAIT_EOL : COLLECT;
          else if (is_eol) state_d = IDLE;
          else             state_d = DISCARD;
        end
        WAIT_EOL: begin
          state_d = is_eol ? IDLE : DISCARD;
        end
        DISCARD: begin
          if (is_eol) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and output next values; cnt/sreg are zeroed whenever a line ends.
  always_comb begin
    cnt_d    = cnt_q;
    sreg_d   = sreg_q;
    data_d   = data_q;
    dvalid_d = 1'b0;
    err_d    = 1'b0;
    if (bus.iCHAR_VALID) begin
      unique case (state_q)
        IDLE: begin
          if (is_hex) begin
            sreg_d = DATA_WIDTH'(nib);
            cnt_d  = CNT_W'(1);
          end else if (!is_eol) begin
            err_d = 1'b1;
          end
        end
        COLLECT: begin
          if (is_hex) begin
            sreg_d = DATA_WIDTH'({sreg_q, nib});
            cnt_d  = cnt_q + CNT_W'(1);
          end else begin
            err_d  = 1'b1;
            sreg_d = '0;
            cnt_d  = '0;
          end
        end
        WAIT_EOL: begin
          if (is_eol) begin
            data_d   = sreg_q;
            dvalid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          sreg_d = '0;
          cnt_d  = '0;
        end
        DISCARD: begin
          sreg_d = '0;
          cnt_d  = '0;
        end
        default: begin
          sreg_d = '0;
          cnt_d  = '0;
        end
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q    <= '0;
      sreg_q   <= '0;
      data_q   <= '0;
      dvalid_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sreg_q   <= sreg_d;
      data_q   <= data_d;
      dvalid_q <= dvalid_d;
      err_q    <= err_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign bus.oDATA       = data_q;
  assign bus.oDATA_VALID = dvalid_q;
  assign bus.oERR        = err_q;
  assign bus.oBUSY       = busy_q;

endmodule

// File: tb/tb_parse_ascii_hex.sv
// Directed bench for parse_ascii_hex: an 8-bit instance and a 16-bit instance
// sharing clock and reset.
module tb_parse_ascii_hex;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  parse_ascii_hex_if #(.DATA_WIDTH(8))  bus8 ();
  parse_ascii_hex_if #(.DATA_WIDTH(16)) bus16 ();

  parse_ascii_hex #(.DATA_WIDTH(8)) dut8 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus8.slave)
  );

  parse_ascii_hex #(.DATA_WIDTH(16)) dut16 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus16.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse counters, sampled on the falling edge away from register updates.
  int          v8 = 0, e8 = 0, v16 = 0, e16 = 0, both8 = 0, both16 = 0;
  logic [7:0]  d8_q[$];
  logic [15:0] d16_q[$];

  always @(negedge CLK) begin
    if (bus8.oDATA_VALID) begin v8++; d8_q.push_back(bus8.oDATA); end
    if (bus8.oERR) e8++;
    if (bus8.oDATA_VALID && bus8.oERR) both8++;
    if (bus16.oDATA_VALID) begin v16++; d16_q.push_back(bus16.oDATA); end
    if (bus16.oERR) e16++;
    if (bus16.oDATA_VALID && bus16.oERR) both16++;
  end

  task automatic clear_mon();
    v8 = 0; e8 = 0; v16 = 0; e16 = 0; both8 = 0; both16 = 0;
    d8_q.delete();
    d16_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // One character per cycle; returns 1 time unit after the sampling edge.
  task automatic send(input bit w16, input logic [7:0] c);
    if (w16) begin bus16.iCHAR = c; bus16.iCHAR_VALID = 1'b1; end
    else     begin bus8.iCHAR  = c; bus8.iCHAR_VALID  = 1'b1; end
    @(posedge CLK);
    #1;
    bus8.iCHAR_VALID  = 1'b0;
    bus16.iCHAR_VALID = 1'b0;
  endtask

  // Consecutive characters with iCHAR_VALID held high throughout.
  task automatic send_str(input bit w16, input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (w16) begin bus16.iCHAR = s[i]; bus16.iCHAR_VALID = 1'b1; end
      else     begin bus8.iCHAR  = s[i]; bus8.iCHAR_VALID  = 1'b1; end
      @(posedge CLK);
      #1;
    end
    bus8.iCHAR_VALID  = 1'b0;
    bus16.iCHAR_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle(2);
    RST = 1'b0;
    idle(1);
    n_checks++;
    if (bus8.oDATA !== 8'h00) begin n_fail++; $display("FAIL reset_data8 got %h want 00", bus8.oDATA); end
    n_checks++;
    if (bus8.oDATA_VALID !== 1'b0 || bus8.oERR !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses got valid=%b err=%b want 0/0", bus8.oDATA_VALID, bus8.oERR);
    end
    n_checks++;
    if (bus8.oBUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus8.oBUSY); end
    n_checks++;
    if (bus16.oDATA !== 16'h0000) begin n_fail++; $display("FAIL reset_data16 got %h want 0000", bus16.oDATA); end
    clear_mon();
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_str(1'b0, "3f\n00\r");
    idle(3);
    n_checks++;
    if (v8 !== 2 || e8 !== 0) begin n_fail++; $display("FAIL b2b_counts got valid=%0d err=%0d want 2/0", v8, e8); end
    n_checks++;
    if (d8_q.size() != 2 || d8_q[0] !== 8'h3F || d8_q[1] !== 8'h00) begin
      n_fail++; $display("FAIL b2b_words got %p want 3f,00", d8_q);
    end
  endtask

  task automatic test_single();
    clear_mon();
    send(1'b0, "A");
    n_checks++;
    if (bus8.oBUSY !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", bus8.oBUSY); end
    send(1'b0, "5");
    send(1'b0, 8'h0D);
    n_checks++;
    if (bus8.oDATA_VALID !== 1'b1 || bus8.oDATA !== 8'hA5) begin
      n_fail++; $display("FAIL single_latency got valid=%b data=%h want 1/a5", bus8.oDATA_VALID, bus8.oDATA);
    end
    send(1'b0, 8'h0A);
    n_checks++;
    if (bus8.oDATA_VALID !== 1'b0 || bus8.oERR !== 1'b0) begin
      n_fail++; $display("FAIL single_lf got valid=%b err=%b want 0/0", bus8.oDATA_VALID, bus8.oERR);
    end
    idle(2);
    n_checks++;
    if (v8 !== 1 || e8 !== 0 || bus8.oDATA !== 8'hA5) begin
      n_fail++; $display("FAIL single_total got valid=%0d err=%0d data=%h want 1/0/a5", v8, e8, bus8.oDATA);
    end
  endtask

  task automatic test_short();
    clear_mon();
    send_str(1'b0, "A\r");
    n_checks++;
    if (bus8.oERR !== 1'b1) begin n_fail++; $display("FAIL short_err_latency got %b want 1", bus8.oERR); end
    idle(2);
    n_checks++;
    if (v8 !== 0 || e8 !== 1 || bus8.oDATA !== 8'hA5) begin
      n_fail++; $display("FAIL short got valid=%0d err=%0d data=%h want 0/1/a5", v8, e8, bus8.oDATA);
    end
    n_checks++;
    if (bus8.oBUSY !== 1'b0) begin n_fail++; $display("FAIL short_busy got %b want 0", bus8.oBUSY); end
  endtask

  task automatic test_long();
    clear_mon();
    send_str(1'b0, "123\r");
    idle(2);
    n_checks++;
    if (v8 !== 0 || e8 !== 1) begin n_fail++; $display("FAIL long got valid=%0d err=%0d want 0/1", v8, e8); end
  endtask

  task automatic test_bad_char();
    clear_mon();
    send_str(1'b0, "G1\r12\n");
    idle(2);
    n_checks++;
    if (e8 !== 1 || v8 !== 1) begin n_fail++; $display("FAIL badchar_counts got valid=%0d err=%0d want 1/1", v8, e8); end
    n_checks++;
    if (d8_q.size() != 1 || d8_q[0] !== 8'h12) begin n_fail++; $display("FAIL badchar_word got %p want 12", d8_q); end
    n_checks++;
    if (both8 !== 0) begin n_fail++; $display("FAIL exclusive_pulses got %0d want 0", both8); end
  endtask

  task automatic test_gaps();
    clear_mon();
    send(1'b0, "e");
    idle(3);
    send(1'b0, "7");
    idle(2);
    send(1'b0, 8'h0A);
    idle(2);
    n_checks++;
    if (v8 !== 1 || e8 !== 0 || bus8.oDATA !== 8'hE7) begin
      n_fail++; $display("FAIL gaps got valid=%0d err=%0d data=%h want 1/0/e7", v8, e8, bus8.oDATA);
    end
  endtask

  task automatic test_reset_midline();
    send(1'b0, "A");
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    n_checks++;
    if (bus8.oDATA !== 8'h00 || bus8.oBUSY !== 1'b0) begin
      n_fail++; $display("FAIL midreset_state got data=%h busy=%b want 00/0", bus8.oDATA, bus8.oBUSY);
    end
    clear_mon();
    send_str(1'b0, "5C\r");
    idle(2);
    n_checks++;
    if (v8 !== 1 || e8 !== 0 || bus8.oDATA !== 8'h5C) begin
      n_fail++; $display("FAIL midreset_line got valid=%0d err=%0d data=%h want 1/0/5c", v8, e8, bus8.oDATA);
    end
  endtask

  task automatic test_wide();
    clear_mon();
    send_str(1'b1, "BEEF\r");
    idle(2);
    n_checks++;
    if (v16 !== 1 || e16 !== 0 || bus16.oDATA !== 16'hBEEF) begin
      n_fail++; $display("FAIL wide_beef got valid=%0d err=%0d data=%h want 1/0/beef", v16, e16, bus16.oDATA);
    end
    clear_mon();
    send_str(1'b1, "beE\n");
    idle(2);
    n_checks++;
    if (v16 !== 0 || e16 !== 1 || bus16.oDATA !== 16'hBEEF) begin
      n_fail++; $display("FAIL wide_short got valid=%0d err=%0d data=%h want 0/1/beef", v16, e16, bus16.oDATA);
    end
    n_checks++;
    if (both16 !== 0) begin n_fail++; $display("FAIL wide_exclusive got %0d want 0", both16); end
  endtask

  initial begin
    bus8.iCHAR        = 8'h00;
    bus8.iCHAR_VALID  = 1'b0;
    bus16.iCHAR       = 8'h00;
    bus16.iCHAR_VALID = 1'b0;
    #1;
    test_reset();
    test_back_to_back();
    test_single();
    test_short();
    test_long();
    test_bad_char();
    test_gaps();
    test_reset_midline();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
